// File: rtl/trakball_pkg.sv
// rtl/trakball_pkg.sv - shared types, output bit map and saturation helper for the trackball emulator
//
// Purpose: common definitions imported by trakball_axis and trakball_emu.
// Contents:
//   axis_state_t - per-axis opto-encoder pulse FSM states
//   TRAK_*       - bit positions inside trak_o
//   sat_add      - symmetric saturating add for a signed accumulator of width w
package trakball_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } axis_state_t;

  localparam int TRAK_H_CLK = 0;
  localparam int TRAK_H_DIR = 1;
  localparam int TRAK_V_CLK = 2;
  localparam int TRAK_V_DIR = 3;

  // Clamp to +/-(2^(w-1)-1). The most negative code is never produced, so
  // the accumulator magnitude stays symmetric and negation cannot overflow.
  function automatic int sat_add(input int a, input int b, input int w);
    int lim;
    int s;
    lim = (1 << (w - 1)) - 1;
    s   = a + b;
    if (s > lim) begin
      return lim;
    end
    if (s < -lim) begin
      return -lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/trakball_axis.sv
// rtl/trakball_axis.sv - one trackball axis: accumulator, joystick acceleration and pulse FSM
//
// Purpose: accumulates mouse and joystick motion for one axis and drains it as
// opto-encoder clock/direction pulses, one count per pulse.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   tick         - 1-cycle pulse-rate strobe shared by both axes
//   step_pos     - joystick direction that adds (right / down)
//   step_neg     - joystick direction that subtracts (left / up)
//   speed        - joystick step shift 0..3
//   mouse_delta  - signed mouse motion, nonzero only in the packet cycle
//   axis_clk     - registered encoder clock
//   axis_dir     - registered encoder direction (1 = negative)
//   busy         - accumulator nonzero or FSM not idle
module trakball_axis
  import trakball_pkg::*;
#(
  parameter int ACCUM_W  = 10,
  parameter int ACC_MAX  = 7,
  parameter int ACC_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              step_pos,
  input  logic              step_neg,
  input  logic [1:0]        speed,
  input  logic signed [9:0] mouse_delta,
  output logic              axis_clk,
  output logic              axis_dir,
  output logic              busy
);

  localparam int ACCEL_W = $clog2(ACC_MAX + 1);
  localparam int HOLD_W  = $clog2(ACC_HOLD);
  localparam int STEP_W  = ACCEL_W + 4;

  logic signed [ACCUM_W-1:0] acc;
  logic signed [ACCUM_W-1:0] acc_next;
  logic [ACCEL_W-1:0]        accel;
  logic [HOLD_W-1:0]         hold;
  axis_state_t               state;
  axis_state_t               state_next;
  logic                      dir_next;
  logic                      clk_next;

  logic                      single;
  logic [STEP_W-1:0]         step_base;
  logic [STEP_W-1:0]         step_mag;
  logic signed [ACCUM_W:0]   joy_mag;
  logic signed [ACCUM_W:0]   joy_term;
  logic signed [ACCUM_W:0]   mouse_term;
  logic signed [ACCUM_W:0]   cons_term;
  logic signed [ACCUM_W:0]   delta;
  logic                      acc_neg;
  logic                      acc_zero;

  assign acc_neg  = acc[ACCUM_W-1];
  assign acc_zero = (acc == '0);
  assign single   = step_pos ^ step_neg;

  assign step_base  = STEP_W'(accel) + STEP_W'(1);
  assign step_mag   = step_base << speed;
  assign joy_mag    = {{(ACCUM_W + 1 - STEP_W){1'b0}}, step_mag};
  assign mouse_term = {{(ACCUM_W + 1 - 10){mouse_delta[9]}}, mouse_delta};

  // All contributions of one cycle are summed before a single saturation so
  // coinciding mouse, joystick and consume terms never lose a count.
  always_comb begin
    joy_term  = '0;
    cons_term = '0;
    if (tick && single) begin
      joy_term = step_pos ? joy_mag : -joy_mag;
    end
    // A pulse drains one count toward zero as it finishes its high phase.
    if (tick && (state == HIGH) && !acc_zero) begin
      cons_term = acc_neg ? '1 : (ACCUM_W + 1)'(1);
    end
    delta    = mouse_term + joy_term - cons_term;
    acc_next = ACCUM_W'(sat_add(int'(acc), int'(delta), ACCUM_W));
  end

  always_comb begin
    state_next = state;
    dir_next   = axis_dir;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!acc_zero) begin
            dir_next   = acc_neg;
            state_next = SETUP;
          end
        end
        SETUP: state_next = HIGH;
        HIGH:  state_next = LOW;
        LOW: begin
          if (acc_zero) begin
            state_next = IDLE;
          end else if (acc_neg == axis_dir) begin
            state_next = HIGH;
          end else begin
            // Reversal goes through SETUP so dir settles before the next clock.
            dir_next   = acc_neg;
            state_next = SETUP;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    clk_next = (state_next == HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      axis_dir <= 1'b0;
      axis_clk <= 1'b0;
      acc      <= '0;
    end else begin
      state    <= state_next;
      axis_dir <= dir_next;
      axis_clk <= clk_next;
      acc      <= acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accel <= '0;
      hold  <= '0;
    end else if (tick) begin
      if (!single) begin
        accel <= '0;
        hold  <= '0;
      end else if (hold == HOLD_W'(ACC_HOLD - 1)) begin
        hold <= '0;
        if (accel != ACCEL_W'(ACC_MAX)) begin
          accel <= accel + 1'b1;
        end
      end else begin
        hold <= hold + 1'b1;
      end
    end
  end

  assign busy = !acc_zero || (state != IDLE);

endmodule

// File: rtl/trakball_emu.sv
// rtl/trakball_emu.sv - joystick and PS/2 mouse to Centipede trackball encoder emulation
//
// Purpose: produces the trakball_i opto-encoder signals for the game core.
// Ports:
//   clk_sys    - 12 MHz system clock
//   reset_n    - asynchronous active-low reset
//   joy_up/down/left/right - active-high joystick directions
//   mouse_i    - hps_io ps2_mouse: [4] X sign, [5] Y sign, [15:8] X, [23:16] Y, [24] toggle
//   speed_i    - joystick step shift 0..3
//   trak_o     - [0] h_clk, [1] h_dir, [2] v_clk, [3] v_dir, [7:4] zero
//   busy_o     - either axis still has motion pending
module trakball_emu
  import trakball_pkg::*;
#(
  parameter int PRESCALE = 12000,
  parameter int ACCUM_W  = 10,
  parameter int ACC_MAX  = 7,
  parameter int ACC_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        joy_up,
  input  logic        joy_down,
  input  logic        joy_left,
  input  logic        joy_right,
  input  logic [24:0] mouse_i,
  input  logic [1:0]  speed_i,
  output logic [7:0]  trak_o,
  output logic        busy_o
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              toggle_q;
  logic              new_pkt;
  logic [8:0]        y9;
  logic signed [9:0] dx;
  logic signed [9:0] dy;
  logic              h_clk;
  logic              h_dir;
  logic              h_busy;
  logic              v_clk;
  logic              v_dir;
  logic              v_busy;
  logic              unused_bits;

  assign unused_bits = ^{mouse_i[7:6], mouse_i[3:0]};

  assign tick = (cnt == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      toggle_q <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      toggle_q <= mouse_i[24];
    end
  end

  // Comparing against the previous cycle's toggle catches every flip, even
  // flips on consecutive cycles, and the delta is applied in that same cycle.
  assign new_pkt = (mouse_i[24] != toggle_q);
  assign y9      = {mouse_i[5], mouse_i[23:16]};
  // Y is negated so that mouse-up moves the cabinet trackball up; ten bits
  // are needed because -(-256) does not fit in nine.
  assign dx = new_pkt ? {mouse_i[4], mouse_i[4], mouse_i[15:8]} : '0;
  assign dy = new_pkt ? -{y9[8], y9} : '0;

  trakball_axis #(
    .ACCUM_W (ACCUM_W),
    .ACC_MAX (ACC_MAX),
    .ACC_HOLD(ACC_HOLD)
  ) u_h (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .tick       (tick),
    .step_pos   (joy_right),
    .step_neg   (joy_left),
    .speed      (speed_i),
    .mouse_delta(dx),
    .axis_clk   (h_clk),
    .axis_dir   (h_dir),
    .busy       (h_busy)
  );

  trakball_axis #(
    .ACCUM_W (ACCUM_W),
    .ACC_MAX (ACC_MAX),
    .ACC_HOLD(ACC_HOLD)
  ) u_v (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .tick       (tick),
    .step_pos   (joy_down),
    .step_neg   (joy_up),
    .speed      (speed_i),
    .mouse_delta(dy),
    .axis_clk   (v_clk),
    .axis_dir   (v_dir),
    .busy       (v_busy)
  );

  always_comb begin
    trak_o             = '0;
    trak_o[TRAK_H_CLK] = h_clk;
    trak_o[TRAK_H_DIR] = h_dir;
    trak_o[TRAK_V_CLK] = v_clk;
    trak_o[TRAK_V_DIR] = v_dir;
  end

  assign busy_o = h_busy | v_busy;

endmodule

// File: tb/tb_trakball_emu.sv
// tb/tb_trakball_emu.sv - directed self-checking bench for trakball_emu
module tb_trakball_emu;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        joy_up;
  logic        joy_down;
  logic        joy_left;
  logic        joy_right;
  logic [24:0] mouse_i;
  logic [1:0]  speed_i;
  logic [7:0]  trak_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  trakball_emu #(
    .PRESCALE(4),
    .ACCUM_W (10),
    .ACC_MAX (7),
    .ACC_HOLD(16)
  ) u_dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .joy_up   (joy_up),
    .joy_down (joy_down),
    .joy_left (joy_left),
    .joy_right(joy_right),
    .mouse_i  (mouse_i),
    .speed_i  (speed_i),
    .trak_o   (trak_o),
    .busy_o   (busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  // Pulse monitor per axis (0 = H, 1 = V), sampled on the falling edge.
  int pulses[2]    = '{0, 0};
  int dir1[2]      = '{0, 0};
  int bad_width[2] = '{0, 0};
  int short_per[2] = '{0, 0};
  int glitch[2]    = '{0, 0};
  int rise_cyc[2]  = '{0, 0};
  int last_rise[2] = '{-100, -100};
  bit prev_clk[2]  = '{1'b0, 1'b0};
  bit rise_dir[2]  = '{1'b0, 1'b0};
  int cyc = 0;

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    for (int a = 0; a < 2; a++) begin
      if (trak_o[2*a] && !prev_clk[a]) begin
        pulses[a] = pulses[a] + 1;
        if (trak_o[2*a+1]) dir1[a] = dir1[a] + 1;
        if (cyc - last_rise[a] < 8) short_per[a] = short_per[a] + 1;
        last_rise[a] = cyc;
        rise_cyc[a]  = cyc;
        rise_dir[a]  = trak_o[2*a+1];
      end else if (trak_o[2*a] && prev_clk[a] && (trak_o[2*a+1] != rise_dir[a])) begin
        glitch[a] = glitch[a] + 1;
      end
      if (!trak_o[2*a] && prev_clk[a] && (cyc - rise_cyc[a] != 4)) begin
        bad_width[a] = bad_width[a] + 1;
      end
      prev_clk[a] = trak_o[2*a];
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_mouse(input bit xs, input logic [7:0] x, input bit ys, input logic [7:0] y);
    mouse_i[4]     = xs;
    mouse_i[15:8]  = x;
    mouse_i[5]     = ys;
    mouse_i[23:16] = y;
    mouse_i[24]    = ~mouse_i[24];
    step();
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (!busy_o) ok = 1'b1;
      else step();
    end
  endtask

  bit ok;
  int bp_h, bd_h, bw_h, bs_h, bg_h, bp_v, bd_v;

  task automatic snap();
    bp_h = pulses[0];
    bd_h = dir1[0];
    bw_h = bad_width[0];
    bs_h = short_per[0];
    bg_h = glitch[0];
    bp_v = pulses[1];
    bd_v = dir1[1];
  endtask

  initial begin
    reset_n   = 1'b0;
    joy_up    = 1'b0;
    joy_down  = 1'b0;
    joy_left  = 1'b0;
    joy_right = 1'b0;
    mouse_i   = '0;
    speed_i   = 2'd0;
    steps(3);
    reset_n = 1'b1;

    // 1: idle after reset
    steps(40);
    chk("idle_trak", trak_o, 8'h00);
    chk("idle_busy", busy_o, 1'b0);

    // 2: X = +3
    snap();
    send_mouse(1'b0, 8'd3, 1'b0, 8'd0);
    chk("x3_busy_set", busy_o, 1'b1);
    wait_idle(200, ok);
    chk("x3_idle", ok, 1'b1);
    chk("x3_pulses", pulses[0] - bp_h, 3);
    chk("x3_dir1", dir1[0] - bd_h, 0);
    chk("x3_width", bad_width[0] - bw_h, 0);
    chk("x3_period", short_per[0] - bs_h, 0);
    chk("x3_trak_end", trak_o, 8'h00);

    // 3: X = -2, then +5 during the second high phase
    snap();
    send_mouse(1'b1, 8'hFE, 1'b0, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (dir1[0] - bd_h == 2) ok = 1'b1;
      else step();
    end
    chk("rev_second_pulse", ok, 1'b1);
    chk("rev_clk_high", trak_o[0], 1'b1);
    send_mouse(1'b0, 8'd5, 1'b0, 8'd0);
    wait_idle(300, ok);
    chk("rev_idle", ok, 1'b1);
    chk("rev_pulses", pulses[0] - bp_h, 5);
    chk("rev_dir1", dir1[0] - bd_h, 2);
    chk("rev_glitch", glitch[0] - bg_h, 0);
    chk("rev_width", bad_width[0] - bw_h, 0);
    chk("rev_trak_end", trak_o, 8'h00);

    // 4: joy_right for 40 ticks at speed 0
    snap();
    joy_right = 1'b1;
    steps(160);
    chk("joy_accel", u_dut.u_h.accel, 2);
    joy_right = 1'b0;
    wait_idle(2000, ok);
    chk("joy_idle", ok, 1'b1);
    chk("joy_pulses", pulses[0] - bp_h, 72);
    chk("joy_dir1", dir1[0] - bd_h, 0);
    chk("joy_v_pulses", pulses[1] - bp_v, 0);
    chk("joy_period", short_per[0] - bs_h, 0);

    // 5: three back-to-back Y = +255 packets saturate the V axis
    snap();
    send_mouse(1'b0, 8'd0, 1'b0, 8'd255);
    send_mouse(1'b0, 8'd0, 1'b0, 8'd255);
    send_mouse(1'b0, 8'd0, 1'b0, 8'd255);
    chk("sat_acc", u_dut.u_v.acc, -511);
    wait_idle(6000, ok);
    chk("sat_idle", ok, 1'b1);
    chk("sat_pulses", pulses[1] - bp_v, 511);
    chk("sat_dir1", dir1[1] - bd_v, 511);
    chk("sat_h_pulses", pulses[0] - bp_h, 0);
    chk("sat_trak_end", trak_o, 8'h08);

    // 6: reset during a high phase with acc = 5
    snap();
    send_mouse(1'b0, 8'd5, 1'b0, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (pulses[0] - bp_h == 1) ok = 1'b1;
      else step();
    end
    chk("rst_in_high", ok, 1'b1);
    chk("rst_pre_trak", trak_o, 8'h09);
    reset_n = 1'b0;
    mouse_i = '0;
    #1;
    chk("rst_async_trak", trak_o, 8'h00);
    chk("rst_async_busy", busy_o, 1'b0);
    steps(2);
    reset_n = 1'b1;
    snap();
    steps(200);
    chk("rst_no_pulses", (pulses[0] - bp_h) + (pulses[1] - bp_v), 0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_trak", trak_o, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
